// File: rtl/jpegls_pkg.sv
// Shared JPEG-LS encode definitions: packer state encoding, marker constants
// and the default codeword/accumulator sizes used across the encode modules.
package jpegls_pkg;

    localparam int CODE_WIDTH_DEF = 32;
    localparam int LEN_WIDTH_DEF  = 6;
    localparam int ACC_WIDTH_DEF  = 40;

    localparam logic [7:0] JPEGLS_MARKER_BYTE = 8'hFF;
    localparam logic [3:0] STUFF_DATA_BITS    = 4'd7;

    typedef enum logic [2:0] {
        PK_IDLE,
        PK_ACTIVE,
        PK_FLUSH,
        PK_FLUSH_STUFF,
        PK_DONE
    } packer_state_e;

endpackage

// File: rtl/jpegls_bit_packer_ctrl_if.sv
// Codeword-in / byte-out channel of the JPEG-LS bit packer, plus its status.
interface jpegls_bit_packer_ctrl_if #(
    parameter int CODE_WIDTH = jpegls_pkg::CODE_WIDTH_DEF,
    parameter int LEN_WIDTH  = jpegls_pkg::LEN_WIDTH_DEF
);
    logic                  code_valid;
    logic                  code_ready;
    logic [CODE_WIDTH-1:0] code_data;
    logic [LEN_WIDTH-1:0]  code_len;
    logic                  flush;
    logic                  byte_valid;
    logic                  byte_ready;
    logic [7:0]            byte_data;
    logic [3:0]            pending_bits;
    logic                  busy;
    logic                  flush_done;

    modport slave (
        input  code_valid, code_data, code_len, flush, byte_ready,
        output code_ready, byte_valid, byte_data, pending_bits, busy, flush_done
    );

    modport master (
        output code_valid, code_data, code_len, flush, byte_ready,
        input  code_ready, byte_valid, byte_data, pending_bits, busy, flush_done
    );
endinterface

// File: rtl/jpegls_bit_accumulator.sv
// MSB-first bit accumulator: drops the emitted byte off the top and appends a
// codeword directly below the remaining valid bits, in the same cycle if needed.
module jpegls_bit_accumulator #(
    parameter int CODE_WIDTH = 32,
    parameter int LEN_WIDTH  = 6,
    parameter int ACC_WIDTH  = 40,
    parameter int CNT_W      = $clog2(ACC_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_shift,
    input  logic [3:0]            i_need,
    input  logic                  i_load,
    input  logic [CODE_WIDTH-1:0] i_code_data,
    input  logic [LEN_WIDTH-1:0]  i_code_len,
    output logic [7:0]            o_top8,
    output logic [CNT_W-1:0]      o_count
);
    logic [ACC_WIDTH-1:0]  r_acc;
    logic [CNT_W-1:0]      r_count;
    logic [ACC_WIDTH-1:0]  w_acc_sh;
    logic [ACC_WIDTH-1:0]  w_ins;
    logic [CNT_W-1:0]      w_cnt_sh;
    logic [CODE_WIDTH-1:0] w_mask;

    always_comb begin
        w_acc_sh = r_acc;
        w_cnt_sh = r_count;
        if (i_shift) begin
            w_acc_sh = r_acc << i_need;
            w_cnt_sh = (r_count > CNT_W'(i_need)) ? r_count - CNT_W'(i_need) : '0;
        end
        // Bits below code_len are cleared so the accumulator tail stays zero,
        // which is what gives the zero padding of the final flushed byte.
        w_mask = ~({CODE_WIDTH{1'b1}} >> i_code_len);
        w_ins  = {i_code_data & w_mask, {(ACC_WIDTH-CODE_WIDTH){1'b0}}} >> w_cnt_sh;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_acc   <= w_acc_sh | w_ins;
            r_count <= w_cnt_sh + CNT_W'(i_code_len);
        end else begin
            r_acc   <= w_acc_sh;
            r_count <= w_cnt_sh;
        end
    end

    assign o_top8  = r_acc[ACC_WIDTH-1 -: 8];
    assign o_count = r_count;
endmodule

// File: rtl/jpegls_bit_packer_ctrl.sv
// JPEG-LS byte packer controller: codeword/byte handshakes, 0xFF bit-stuffing
// and the end-of-scan flush sequence around the bit accumulator.
module jpegls_bit_packer_ctrl
    import jpegls_pkg::*;
#(
    parameter int CODE_WIDTH = CODE_WIDTH_DEF,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    jpegls_bit_packer_ctrl_if.slave bus_if
);
    localparam int CNT_W = $clog2(ACC_WIDTH + 1);

    packer_state_e    r_state;
    logic             r_stuff;
    logic [CNT_W-1:0] w_count;
    logic [7:0]       w_top8;
    logic [3:0]       w_need;
    logic             w_run;
    logic             w_byte_valid;
    logic [7:0]       w_byte_data;
    logic             w_byte_hs;
    logic             w_code_ready;
    logic             w_code_hs;

    assign w_need = r_stuff ? STUFF_DATA_BITS : 4'd8;
    assign w_run  = (r_state == PK_IDLE) || (r_state == PK_ACTIVE);

    // During flush any non-empty remainder goes out as a padded byte.
    assign w_byte_valid = ((w_run || r_state == PK_FLUSH) && w_count >= CNT_W'(w_need))
                       || (r_state == PK_FLUSH && w_count != '0)
                       || (r_state == PK_FLUSH_STUFF);
    assign w_byte_data  = (r_state == PK_FLUSH_STUFF) ? 8'h00 :
                          r_stuff ? {1'b0, w_top8[7:1]} : w_top8;
    assign w_byte_hs    = w_byte_valid && bus_if.byte_ready;

    // count <= 8 at accept keeps count + CODE_WIDTH within the accumulator.
    assign w_code_ready = w_run && (w_count <= CNT_W'(8));
    assign w_code_hs    = bus_if.code_valid && w_code_ready;

    jpegls_bit_accumulator #(
        .CODE_WIDTH (CODE_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .CNT_W      (CNT_W)
    ) u_acc (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_shift     (w_byte_hs),
        .i_need      (w_need),
        .i_load      (w_code_hs),
        .i_code_data (bus_if.code_data),
        .i_code_len  (bus_if.code_len),
        .o_top8      (w_top8),
        .o_count     (w_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= PK_IDLE;
            r_stuff <= 1'b0;
        end else begin
            if (w_byte_hs)
                r_stuff <= (w_byte_data == JPEGLS_MARKER_BYTE);
            case (r_state)
                PK_IDLE: begin
                    if (w_code_hs && bus_if.code_len != '0)
                        r_state <= bus_if.flush ? PK_FLUSH : PK_ACTIVE;
                end
                PK_ACTIVE: begin
                    if (bus_if.flush)
                        r_state <= PK_FLUSH;
                end
                PK_FLUSH: begin
                    if (w_count == '0)
                        r_state <= r_stuff ? PK_FLUSH_STUFF : PK_DONE;
                end
                PK_FLUSH_STUFF: begin
                    if (w_byte_hs)
                        r_state <= PK_DONE;
                end
                PK_DONE:  r_state <= PK_IDLE;
                default:  r_state <= PK_IDLE;
            endcase
        end
    end

    assign bus_if.code_ready   = w_code_ready;
    assign bus_if.byte_valid   = w_byte_valid;
    assign bus_if.byte_data    = w_byte_data;
    assign bus_if.pending_bits = (w_count > CNT_W'(15)) ? 4'd15 : w_count[3:0];
    assign bus_if.busy         = (r_state != PK_IDLE) || (w_count != '0);
    assign bus_if.flush_done   = (r_state == PK_DONE);
endmodule

// File: tb/tb_jpegls_bit_packer_ctrl.sv
// Directed bench for the JPEG-LS bit packer; expected bytes go into a queue
// and an independent monitor pops them on every byte handshake.
module tb_jpegls_bit_packer_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    jpegls_bit_packer_ctrl_if #(.CODE_WIDTH(32), .LEN_WIDTH(6)) ifc();

    jpegls_bit_packer_ctrl #(.CODE_WIDTH(32), .LEN_WIDTH(6), .ACC_WIDTH(40)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (ifc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_t = 0;
    int prev_t = 0;
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: inputs only change just after posedge, so the negedge view
    // is what the next posedge will handshake.
    always @(negedge clk) begin
        if (rst_n && ifc.byte_valid && ifc.byte_ready) begin
            logic [7:0] e;
            checks++;
            prev_t = last_t;
            last_t = cyc;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL byte_unexpected got=%02h expected=none", ifc.byte_data);
            end else begin
                e = exp_q.pop_front();
                if (ifc.byte_data !== e) begin
                    errors++;
                    $display("FAIL byte_data got=%02h expected=%02h", ifc.byte_data, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [5:0] l);
        int n = 0;
        ifc.code_valid = 1'b1;
        ifc.code_data  = d;
        ifc.code_len   = l;
        forever begin
            @(negedge clk);
            if (ifc.code_ready) break;
            n++;
            if (n > 200) begin
                chk("send_timeout", 32'(ifc.code_ready), 1);
                break;
            end
        end
        @(posedge clk); #1;
        ifc.code_valid = 1'b0;
    endtask

    task automatic do_flush();
        ifc.flush = 1'b1;
        @(posedge clk); #1;
        ifc.flush = 1'b0;
    endtask

    task automatic drain(input string name);
        logic ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !ifc.byte_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 32'(ok), 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input string name);
        logic seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (ifc.flush_done) begin
                seen = 1'b1;
                break;
            end
        end
        chk(name, 32'(seen), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        ifc.code_valid = 1'b0;
        ifc.code_data  = '0;
        ifc.code_len   = '0;
        ifc.flush      = 1'b0;
        ifc.byte_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_byte_valid", 32'(ifc.byte_valid), 0);
        chk("rst_flush_done", 32'(ifc.flush_done), 0);
        chk("rst_code_ready", 32'(ifc.code_ready), 1);
        chk("rst_busy", 32'(ifc.busy), 0);
        chk("rst_pending", 32'(ifc.pending_bits), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero-length code is a no-op
        send(32'hFFFF_FFFF, 6'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("len0_busy", 32'(ifc.busy), 0);
        chk("len0_pending", 32'(ifc.pending_bits), 0);

        // Two nibbles form one byte
        exp_q.push_back(8'hA5);
        send(32'hA000_0000, 6'd4);
        send(32'h5000_0000, 6'd4);
        drain("t1_drain");
        chk("t1_pending", 32'(ifc.pending_bits), 0);

        // 0xFF followed by a stuffed 7-bit byte, which is not a marker itself
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h7F);
        send(32'hFF00_0000, 6'd8);
        send(32'hFE00_0000, 6'd7);
        drain("t2_drain");
        do_flush();
        wait_done("t2_flush_done");

        // 0xFF as the last byte forces a trailing 0x00 on flush
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        send(32'hFF00_0000, 6'd8);
        do_flush();
        wait_done("t2b_flush_done");
        chk("t2b_queue", 32'(exp_q.size()), 0);

        // Full-width code under backpressure
        ifc.byte_ready = 1'b0;
        exp_q.push_back(8'hDE);
        exp_q.push_back(8'hAD);
        exp_q.push_back(8'hBE);
        exp_q.push_back(8'hEF);
        send(32'hDEAD_BEEF, 6'd32);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", 32'(ifc.byte_valid), 1);
            chk("t3_hold_data", 32'(ifc.byte_data), 32'hDE);
            chk("t3_code_ready", 32'(ifc.code_ready), 0);
            chk("t3_pending_sat", 32'(ifc.pending_bits), 15);
        end
        @(posedge clk); #1;
        ifc.byte_ready = 1'b1;
        drain("t3_drain");

        // Partial byte is zero-padded on flush
        exp_q.push_back(8'hA0);
        send(32'hA000_0000, 6'd3);
        do_flush();
        wait_done("t4_flush_done");
        chk("t4_busy", 32'(ifc.busy), 0);

        // Back-to-back 12-bit codes
        exp_q.push_back(8'hAB);
        exp_q.push_back(8'hCD);
        exp_q.push_back(8'hEF);
        send(32'hABC0_0000, 6'd12);
        send(32'hDEF0_0000, 6'd12);
        drain("t5_drain");
        chk("t5_consecutive", 32'(last_t - prev_t), 1);

        // Asynchronous reset discards held bits
        ifc.byte_ready = 1'b0;
        send(32'h1234_5678, 6'd13);
        @(negedge clk);
        chk("t6_pre_valid", 32'(ifc.byte_valid), 1);
        chk("t6_pre_pending", 32'(ifc.pending_bits), 13);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(ifc.byte_valid), 0);
        chk("t6_rst_pending", 32'(ifc.pending_bits), 0);
        chk("t6_rst_busy", 32'(ifc.busy), 0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ifc.byte_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("t6_post_valid", 32'(ifc.byte_valid), 0);
        chk("final_queue", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1);
    end
endmodule
